// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: turns field-level requests into 32-bit words and
// streams them through a small FIFO into sequential instruction-memory writes.
module legv8_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 4,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rn,
   input  logic [4:0]        req_rm,
   input  logic [18:0]       req_imm,
   input  logic              flush,
   input  logic              imem_busy,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              err,
   output logic              idle
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0]     FULL = CW'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      K_LDUR = 3'd0, K_STUR = 3'd1, K_CBZ = 3'd2, K_ADD = 3'd3,
      K_SUB  = 3'd4, K_AND  = 3'd5, K_ORR = 3'd6, K_RSVD = 3'd7
   } kind_e;

   kind_e             kind;
   logic              d_ok;
   logic [31:0]       enc_word;
   logic              enc_drop;
   logic              accept, push, pop;

   logic [31:0]       mem_q [DEPTH];
   logic [IW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              err_q, err_d;

   assign kind = kind_e'(req_kind);
   // D-type offset fits in 9 signed bits when bits 18..8 are all copies of bit 8
   assign d_ok = (&req_imm[18:8]) || !(|req_imm[18:8]);

   always_comb begin
      enc_word = '0;
      enc_drop = 1'b0;
      case (kind)
         K_LDUR:  begin
            enc_word = {11'b11111000010, req_imm[8:0], 2'b00, req_rn, req_rd};
            enc_drop = !d_ok;
         end
         K_STUR:  begin
            enc_word = {11'b11111000000, req_imm[8:0], 2'b00, req_rn, req_rd};
            enc_drop = !d_ok;
         end
         K_CBZ:   enc_word = {8'b10110100, req_imm, req_rd};
         K_ADD:   enc_word = {11'b10001011000, req_rm, 6'b000000, req_rn, req_rd};
         K_SUB:   enc_word = {11'b11001011000, req_rm, 6'b000000, req_rn, req_rd};
         K_AND:   enc_word = {11'b10001010000, req_rm, 6'b000000, req_rn, req_rd};
         K_ORR:   enc_word = {11'b10101010000, req_rm, 6'b000000, req_rn, req_rd};
         default: enc_drop = 1'b1;
      endcase
   end

   assign idle       = (count_q == '0);
   assign req_ready  = (count_q < FULL) && !flush;
   assign imem_we    = !idle && !imem_busy && !flush;
   assign imem_wdata = idle ? '0 : mem_q[rd_q];
   assign imem_addr  = ptr_q;
   assign err        = err_q;

   assign accept = req_valid && req_ready;
   assign push   = accept && !enc_drop;
   assign pop    = imem_we;

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      err_d   = err_q;
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
         ptr_d   = BASE;
         err_d   = 1'b0;
      end else begin
         if (pop) begin
            rd_d  = rd_q + 1'b1;
            ptr_d = ptr_q + ADDR_W'(4);
         end
         if (push) wr_d = wr_q + 1'b1;
         if (accept && enc_drop) err_d = 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ptr_q   <= BASE;
         err_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= enc_word;
   end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model, on an 8-bit and a 4-bit address instance.
module tb_legv8_instr_encoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_kind = '0;
   logic [4:0]  req_rd = '0, req_rn = '0, req_rm = '0;
   logic [18:0] req_imm = '0;
   logic        flush = 1'b0;
   logic        imem_busy = 1'b0;

   logic        a_ready, a_we, a_err, a_idle;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic        b_ready, b_we, b_err, b_idle;
   logic [3:0]  b_addr;
   logic [31:0] b_wdata;

   int total = 0;
   int bad = 0;

   logic [31:0] mq[$];
   int unsigned mptr = 0;
   logic        merr = 1'b0;

   always #5 clk = ~clk;

   legv8_instr_encoder #(.ADDR_W(8), .DEPTH(DEPTH), .BASE_ADDR(0)) dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
      .req_kind(req_kind), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
      .req_imm(req_imm), .flush(flush), .imem_busy(imem_busy), .imem_we(a_we),
      .imem_addr(a_addr), .imem_wdata(a_wdata), .err(a_err), .idle(a_idle));

   legv8_instr_encoder #(.ADDR_W(4), .DEPTH(DEPTH), .BASE_ADDR(0)) dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
      .req_kind(req_kind), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
      .req_imm(req_imm), .flush(flush), .imem_busy(imem_busy), .imem_we(b_we),
      .imem_addr(b_addr), .imem_wdata(b_wdata), .err(b_err), .idle(b_idle));

   // Reference encoding from opcode values and integer offsets
   function automatic void ref_encode(input logic [2:0] k, input logic [4:0] rd,
                                      input logic [4:0] rn, input logic [4:0] rm,
                                      input logic [18:0] imm,
                                      output logic [31:0] w, output logic drop);
      int          v;
      int unsigned uv, opc;
      v    = int'(signed'(imm));
      uv   = unsigned'(v);
      w    = '0;
      drop = 1'b0;
      opc  = 0;
      case (k)
         3'd0, 3'd1: begin
            drop = (v < -256) || (v > 255);
            opc  = (k == 3'd0) ? 32'b11111000010 : 32'b11111000000;
            w    = (opc << 21) | ((uv % 512) << 12) | (32'(rn) << 5) | 32'(rd);
         end
         3'd2: w = (32'b10110100 << 24) | ((uv % 524288) << 5) | 32'(rd);
         3'd3, 3'd4, 3'd5, 3'd6: begin
            case (k)
               3'd3:    opc = 32'b10001011000;
               3'd4:    opc = 32'b11001011000;
               3'd5:    opc = 32'b10001010000;
               default: opc = 32'b10101010000;
            endcase
            w = (opc << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
         end
         default: drop = 1'b1;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [2:0] k, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [18:0] imm,
                        input logic b, input logic f);
      @(negedge clk);
      req_valid = v; req_kind = k; req_rd = rd; req_rn = rn; req_rm = rm;
      req_imm = imm; imem_busy = b; flush = f;
      #1;
   endtask

   task automatic idle_cyc(input logic b);
      drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0, b, 1'b0);
   endtask

   // Advance the model across the coming clock edge using the applied inputs
   task automatic adv();
      logic [31:0] w;
      logic        d, rdy, we;
      rdy = (mq.size() < DEPTH) && !flush;
      we  = (mq.size() != 0) && !imem_busy && !flush;
      if (flush) begin
         mq.delete(); mptr = 0; merr = 1'b0;
      end else begin
         if (we) begin
            void'(mq.pop_front());
            mptr += 4;
         end
         if (req_valid && rdy) begin
            ref_encode(req_kind, req_rd, req_rn, req_rm, req_imm, w, d);
            if (d) merr = 1'b1;
            else mq.push_back(w);
         end
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = 1'b0; imem_busy = 1'b0; flush = 1'b0;
      mq.delete(); mptr = 0; merr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
      total++; if (a_idle !== 1'b1 || b_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b/%b want=1", a_idle, b_idle); end
      total++; if (a_we !== 1'b0 || b_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b/%b want=0", a_we, b_we); end
      total++; if (a_addr !== 8'h00 || b_addr !== 4'h0) begin bad++; $display("FAIL reset_addr got=%h/%h want=0", a_addr, b_addr); end
      total++; if (a_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", a_wdata); end
      total++; if (a_err !== 1'b0 || b_err !== 1'b0 || b_ready !== 1'b1) begin bad++; $display("FAIL reset_err got=%b/%b rdy=%b want=0/0/1", a_err, b_err, b_ready); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_ldur();
      do_reset();
      drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd0, 19'd8, 1'b0, 1'b0);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL ldur_ready got=%b want=1", a_ready); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b1) begin bad++; $display("FAIL ldur_we got=%b want=1", a_we); end
      total++; if (a_wdata !== 32'hF8408041) begin bad++; $display("FAIL ldur_data got=%h want=F8408041", a_wdata); end
      total++; if (a_addr !== 8'h00) begin bad++; $display("FAIL ldur_addr got=%h want=00", a_addr); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_idle !== 1'b1 || a_we !== 1'b0) begin bad++; $display("FAIL ldur_idle got idle=%b we=%b want 1/0", a_idle, a_we); end
      adv();
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0, 1'b0);
      adv();
      drive(1'b1, 3'd1, 5'd1, 5'd2, 5'd0, 19'd8, 1'b0, 1'b0);
      total++; if (a_we !== 1'b1 || a_wdata !== 32'h8B020023 || a_addr !== 8'h00) begin bad++; $display("FAIL b2b_add got we=%b %h@%h want 1 8B020023@00", a_we, a_wdata, a_addr); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b1 || a_wdata !== 32'hF8008041 || a_addr !== 8'h04) begin bad++; $display("FAIL b2b_stur got we=%b %h@%h want 1 F8008041@04", a_we, a_wdata, a_addr); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", a_idle); end
      adv();
   endtask

   task automatic test_bounds();
      do_reset();
      drive(1'b1, 3'd2, 5'd5, 5'd0, 5'd0, 19'h7FFFE, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      total++; if (a_wdata !== 32'hB4FFFFC5) begin bad++; $display("FAIL cbz_data got=%h want=B4FFFFC5", a_wdata); end
      adv();
      drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 19'h7FF00, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      total++; if (a_wdata !== 32'hF8500000 || a_err !== 1'b0) begin bad++; $display("FAIL ldur_m256 got=%h err=%b want F8500000 0", a_wdata, a_err); end
      adv();
      drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 19'd255, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      total++; if (a_wdata !== 32'hF84FF000 || a_err !== 1'b0) begin bad++; $display("FAIL ldur_255 got=%h err=%b want F84FF000 0", a_wdata, a_err); end
      adv();
      drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 19'd256, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b0 || a_err !== 1'b1) begin bad++; $display("FAIL ldur_256 got we=%b err=%b want 0/1", a_we, a_err); end
      adv();
   endtask

   task automatic test_busy_full();
      logic sent5;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3'd0, 5'(i), 5'd0, 5'd0, 19'd0, 1'b1, 1'b0);
         total++; if (a_ready !== (i < 4) || a_we !== 1'b0) begin bad++; $display("FAIL full_ready i=%0d got rdy=%b we=%b want %b/0", i, a_ready, a_we, (i < 4)); end
         adv();
      end
      sent5 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         drive(!sent5, 3'd0, 5'd4, 5'd0, 5'd0, 19'd0, 1'b0, 1'b0);
         if (c < 2) begin
            total++; if (a_ready !== (c == 1)) begin bad++; $display("FAIL full_reopen c=%0d got=%b want=%b", c, a_ready, (c == 1)); end
         end
         total++; if (a_we !== (c < 5)) begin bad++; $display("FAIL full_we c=%0d got=%b want=%b", c, a_we, (c < 5)); end
         if (c < 5) begin
            total++; if (a_addr !== 8'(4 * c) || a_wdata !== (32'hF8400000 | 32'(c))) begin bad++; $display("FAIL full_write c=%0d got %h@%h want %h@%h", c, a_wdata, a_addr, 32'hF8400000 | 32'(c), 8'(4 * c)); end
         end
         if (req_valid && a_ready) sent5 = 1'b1;
         adv();
      end
   endtask

   task automatic test_drop_flush();
      do_reset();
      drive(1'b1, 3'd0, 5'd9, 5'd0, 5'd0, 19'd0, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      adv();
      drive(1'b1, 3'd1, 5'd1, 5'd1, 5'd0, 19'd300, 1'b0, 1'b0);
      total++; if (a_ready !== 1'b1 || a_err !== 1'b0) begin bad++; $display("FAIL drop_imm got rdy=%b err=%b want 1/0", a_ready, a_err); end
      adv();
      drive(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0, 1'b0);
      total++; if (a_ready !== 1'b1 || a_err !== 1'b1 || a_we !== 1'b0) begin bad++; $display("FAIL drop_rsvd got rdy=%b err=%b we=%b want 1/1/0", a_ready, a_err, a_we); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b0 || a_err !== 1'b1 || a_idle !== 1'b1) begin bad++; $display("FAIL drop_after got we=%b err=%b idle=%b want 0/1/1", a_we, a_err, a_idle); end
      adv();
      drive(1'b1, 3'd0, 5'd7, 5'd0, 5'd0, 19'd0, 1'b1, 1'b0);
      adv();
      drive(1'b1, 3'd0, 5'd8, 5'd0, 5'd0, 19'd0, 1'b0, 1'b1);
      total++; if (a_we !== 1'b0 || a_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle got we=%b rdy=%b want 0/0", a_we, a_ready); end
      adv();
      idle_cyc(1'b0);
      total++; if (a_err !== 1'b0 || a_idle !== 1'b1 || a_addr !== 8'h00) begin bad++; $display("FAIL flush_after got err=%b idle=%b addr=%h want 0/1/00", a_err, a_idle, a_addr); end
      adv();
      drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd0, 19'd8, 1'b0, 1'b0);
      adv();
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b1 || a_addr !== 8'h00 || a_wdata !== 32'hF8408041) begin bad++; $display("FAIL flush_next got we=%b %h@%h want 1 F8408041@00", a_we, a_wdata, a_addr); end
      adv();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive(c < 5, 3'd0, 5'(c), 5'd0, 5'd0, 19'd0, 1'b0, 1'b0);
         if (c >= 1 && c <= 5) begin
            total++; if (b_we !== 1'b1 || b_addr !== 4'((4 * (c - 1)) % 16) || a_addr !== 8'(4 * (c - 1))) begin bad++; $display("FAIL wrap c=%0d got we=%b b=%h a=%h want 1 %h %h", c, b_we, b_addr, a_addr, 4'((4 * (c - 1)) % 16), 8'(4 * (c - 1))); end
         end
         if (c == 6) begin
            total++; if (b_idle !== 1'b1 || b_we !== 1'b0) begin bad++; $display("FAIL wrap_idle got idle=%b we=%b want 1/0", b_idle, b_we); end
         end
         adv();
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'd0, 5'(i), 5'd0, 5'd0, 19'd0, 1'b1, 1'b0);
         adv();
      end
      @(negedge clk);
      req_valid = 1'b0; imem_busy = 1'b0;
      reset = 1'b1;
      mq.delete(); mptr = 0; merr = 1'b0;
      #1;
      total++; if (a_we !== 1'b0 || b_we !== 1'b0 || a_idle !== 1'b1 || b_idle !== 1'b1) begin bad++; $display("FAIL rst_mid got we=%b/%b idle=%b/%b want 0/0 1/1", a_we, b_we, a_idle, b_idle); end
      @(negedge clk);
      reset = 1'b0;
      idle_cyc(1'b0);
      total++; if (a_we !== 1'b0 || a_addr !== 8'h00) begin bad++; $display("FAIL rst_mid_after got we=%b addr=%h want 0/00", a_we, a_addr); end
      adv();
   endtask

   task automatic test_random();
      logic [18:0] imm;
      logic [31:0] ew;
      logic        erdy, ewe;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(1) == 0) imm = 19'(int'($urandom_range(600)) - 300);
         else imm = 19'($urandom);
         drive($urandom_range(3) != 0, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               imm, $urandom_range(3) == 0, $urandom_range(39) == 0);
         erdy = (mq.size() < DEPTH) && !flush;
         ewe  = (mq.size() != 0) && !imem_busy && !flush;
         ew   = (mq.size() != 0) ? mq[0] : 32'h0;
         total++; if (a_ready !== erdy || b_ready !== erdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b/%b want=%b", n, a_ready, b_ready, erdy); end
         total++; if (a_we !== ewe || b_we !== ewe) begin bad++; $display("FAIL rnd_we n=%0d got=%b/%b want=%b", n, a_we, b_we, ewe); end
         total++; if (a_wdata !== ew || b_wdata !== ew) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h/%h want=%h", n, a_wdata, b_wdata, ew); end
         total++; if (a_addr !== 8'(mptr % 256) || b_addr !== 4'(mptr % 16)) begin bad++; $display("FAIL rnd_addr n=%0d got=%h/%h want=%h/%h", n, a_addr, b_addr, 8'(mptr % 256), 4'(mptr % 16)); end
         total++; if (a_err !== merr || b_err !== merr) begin bad++; $display("FAIL rnd_err n=%0d got=%b/%b want=%b", n, a_err, b_err, merr); end
         total++; if (a_idle !== (mq.size() == 0) || b_idle !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_idle n=%0d got=%b/%b want=%b", n, a_idle, b_idle, (mq.size() == 0)); end
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_ldur();
      test_back_to_back();
      test_bounds();
      test_busy_full();
      test_drop_flush();
      test_wrap();
      test_reset_mid_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
